syncfifo1_enq_arbiter: RTL and testbench



---
 rtl/syncfifo1_enq_arbiter.sv | 81 ++++++++
 tb/tb_syncfifo1_enq_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/syncfifo1_enq_arbiter.sv
// syncfifo1_enq_arbiter: round-robin arbiter feeding one staging word into a single-entry crossing FIFO.
// Define SYNCFIFO1_ARB_TAG_EN to prepend the source requester index to FIFO_D_IN.
module syncfifo1_enq_arbiter #(
  parameter int numReq    = 4,
  parameter int dataWidth = 8,
  parameter int idxWidth  = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [numReq-1:0]             REQ_ENQ,
  input  logic [numReq*dataWidth-1:0]   REQ_D_IN,
  output logic [numReq-1:0]             REQ_RDY,
  output logic                          FIFO_ENQ,
`ifdef SYNCFIFO1_ARB_TAG_EN
  output logic [dataWidth+idxWidth-1:0] FIFO_D_IN,
`else
  output logic [dataWidth-1:0]          FIFO_D_IN,
`endif
  input  logic                          FIFO_FULL_N,
  output logic [idxWidth-1:0]           GRANT_IDX,
  output logic                          BUSY
);
  typedef enum logic {EMPTY, HOLD} state_t;
  state_t                r_state;
  logic [dataWidth-1:0]  r_hold_data;
  logic [idxWidth-1:0]   r_hold_idx;
  logic [idxWidth-1:0]   r_last_grant;
  logic                  w_any;
  logic [idxWidth-1:0]   w_win;
  logic [numReq-1:0]     w_onehot;
  logic [dataWidth-1:0]  w_win_data;
  logic                  w_can_accept;
  logic                  w_accept;
  logic                  w_drain;
  // Scan downward so the last hit is the first requester after last_grant.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = numReq; k >= 1; k--) begin
      if (REQ_ENQ[idxWidth'((int'(r_last_grant) + k) % numReq)]) begin
        w_any = 1'b1;
        w_win = idxWidth'((int'(r_last_grant) + k) % numReq);
      end
    end
  end
  always_comb begin
    w_onehot   = '0;
    w_win_data = '0;
    for (int i = 0; i < numReq; i++) begin
      w_onehot[i] = (w_win == idxWidth'(i));
      w_win_data  = (w_win == idxWidth'(i)) ? REQ_D_IN[i*dataWidth +: dataWidth] : w_win_data;
    end
  end
  assign w_drain      = (r_state == HOLD) && FIFO_FULL_N;
  assign w_can_accept = (r_state == EMPTY) || FIFO_FULL_N;
  assign w_accept     = w_any && w_can_accept;
  assign REQ_RDY      = (!RST && w_accept) ? w_onehot : '0;
  assign FIFO_ENQ     = !RST && w_drain;
  assign GRANT_IDX    = r_hold_idx;
  assign BUSY         = (r_state == HOLD);
`ifdef SYNCFIFO1_ARB_TAG_EN
  assign FIFO_D_IN    = {r_hold_idx, r_hold_data};
`else
  assign FIFO_D_IN    = r_hold_data;
`endif
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= EMPTY;
      r_hold_data  <= '0;
      r_hold_idx   <= '0;
      r_last_grant <= idxWidth'(numReq - 1);
    end else if (w_accept) begin
      r_state      <= HOLD;
      r_hold_data  <= w_win_data;
      r_hold_idx   <= w_win;
      r_last_grant <= w_win;
    end else if (w_drain) begin
      r_state      <= EMPTY;
    end
  end
endmodule

// File: tb/tb_syncfifo1_enq_arbiter.sv
// tb_syncfifo1_enq_arbiter: directed scenarios plus random traffic against a queue-level reference model.
module tb_syncfifo1_enq_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
`ifdef SYNCFIFO1_ARB_TAG_EN
  localparam int FW = DW + IW;
`else
  localparam int FW = DW;
`endif
  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [N-1:0]    REQ_ENQ = '0;
  logic [N*DW-1:0] REQ_D_IN = '0;
  logic [N-1:0]    REQ_RDY;
  logic            FIFO_ENQ;
  logic [FW-1:0]   FIFO_D_IN;
  logic            FIFO_FULL_N = 1'b1;
  logic [IW-1:0]   GRANT_IDX;
  logic            BUSY;
  int n_checks = 0;
  int n_fail   = 0;
  bit       m_busy = 0;
  bit [7:0] m_data = 0;
  int       m_idx  = 0;
  int       m_last = N - 1;
  logic [N-1:0]  obs_rdy;
  logic          obs_enq;
  logic [FW-1:0] obs_dout;
  logic [FW-1:0] drained[$];
  syncfifo1_enq_arbiter #(.numReq(N), .dataWidth(DW), .idxWidth(IW)) dut (
    .CLK(CLK), .RST(RST), .REQ_ENQ(REQ_ENQ), .REQ_D_IN(REQ_D_IN), .REQ_RDY(REQ_RDY),
    .FIFO_ENQ(FIFO_ENQ), .FIFO_D_IN(FIFO_D_IN), .FIFO_FULL_N(FIFO_FULL_N),
    .GRANT_IDX(GRANT_IDX), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] word(input int idx, input bit [7:0] d);
`ifdef SYNCFIFO1_ARB_TAG_EN
    return 32'((idx << DW) | int'(d));
`else
    return 32'(d);
`endif
  endfunction
  // One cycle, entered and left at a negedge: drive, compare to model, clock, advance model.
  task automatic step(input logic [N-1:0] enq, input logic [N*DW-1:0] din, input logic fn);
    int  win;
    bit  can;
    bit  exp_enq;
    logic [N-1:0] exp_rdy;
    REQ_ENQ = enq;
    REQ_D_IN = din;
    FIFO_FULL_N = fn;
    #1;
    win = -1;
    for (int k = 1; k <= N && win < 0; k++) if (enq[(m_last + k) % N]) win = (m_last + k) % N;
    can = !m_busy || fn;
    exp_rdy = (can && win >= 0) ? N'(1 << win) : '0;
    exp_enq = m_busy && fn;
    obs_rdy = REQ_RDY;
    obs_enq = FIFO_ENQ;
    obs_dout = FIFO_D_IN;
    check("req_rdy", 32'(REQ_RDY), 32'(exp_rdy));
    check("fifo_enq", 32'(FIFO_ENQ), 32'(exp_enq));
    check("busy", 32'(BUSY), 32'(m_busy));
    check("fifo_d_in", 32'(FIFO_D_IN), word(m_idx, m_data));
    if (m_busy) check("grant_idx", 32'(GRANT_IDX), 32'(m_idx));
    if (FIFO_ENQ) drained.push_back(FIFO_D_IN);
    @(posedge CLK);
    if (can && win >= 0) begin
      m_busy = 1;
      m_data = din[win*DW +: DW];
      m_idx  = win;
      m_last = win;
    end else if (exp_enq) m_busy = 0;
    @(negedge CLK);
  endtask
  task automatic do_reset();
    RST = 1'b1;
    #1;
    check("rst_rdy", 32'(REQ_RDY), 0);
    check("rst_enq", 32'(FIFO_ENQ), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_grant", 32'(GRANT_IDX), 0);
    check("rst_dout", 32'(FIFO_D_IN), 0);
    m_busy = 0; m_data = 0; m_idx = 0; m_last = N - 1;
    @(negedge CLK);
    RST = 1'b0;
  endtask
  initial begin
    logic [N*DW-1:0] rr_data;
    rr_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    REQ_ENQ = 4'b1111;
    @(negedge CLK);
    do_reset();
    step(4'b1111, rr_data, 1'b1);
    check("first_rdy", 32'(obs_rdy), 32'b0001);
    drained.delete();
    repeat (5) step(4'b1111, rr_data, 1'b1);
    check("rr_count", drained.size(), 5);
    for (int i = 0; i < 5 && i < drained.size(); i++)
      check("rr_seq", 32'(drained[i]), word(i % 4, 8'hA0 + 8'(i % 4)));
    repeat (5) begin
      step(4'b0100, rr_data, 1'b0);
      check("bp_rdy", 32'(obs_rdy), 0);
      check("bp_enq", 32'(obs_enq), 0);
    end
    check("bp_hold", 32'(GRANT_IDX), 1);
    step(4'b0100, rr_data, 1'b1);
    check("bp_release_rdy", 32'(obs_rdy), 32'b0100);
    check("bp_release_enq", 32'(obs_enq), 1);
    step(4'b1000, rr_data, 1'b1);
    repeat (10) step(4'b0000, rr_data, 1'b1);
    step(4'b1001, rr_data, 1'b1);
    check("wrap_rdy", 32'(obs_rdy), 32'b0001);
    step(4'b1001, rr_data, 1'b1);
    check("next_rdy", 32'(obs_rdy), 32'b1000);
    step(4'b0000, rr_data, 1'b0);
    check("pre_rst_busy", 32'(BUSY), 1);
    do_reset();
    drained.delete();
    repeat (3) step(4'b0000, rr_data, 1'b1);
    check("post_rst_no_enq", drained.size(), 0);
    step(4'b0100, {8'h00, 8'h5C, 8'h00, 8'h00}, 1'b1);
    step(4'b0000, '0, 1'b1);
    check("tag_enq", 32'(obs_enq), 1);
`ifdef SYNCFIFO1_ARB_TAG_EN
    check("tag_dout", 32'(obs_dout), 32'b10_0101_1100);
`else
    check("tag_dout", 32'(obs_dout), 32'h5C);
`endif
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      step(N'($urandom), {$urandom}, $urandom_range(0, 3) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule
